line_rasterizer: RTL and testbench
==================================

// Module: line_rasterizer
// PURPOSE
//  Bresenham line rasterizer feeding the rasterizer->framebuffer-writer pixel FIFO.
//  Accepts one line command (two endpoints + colour) and emits one 96-bit pixel word per
//  cycle into the FIFO, stalling on fifo_full. The downstream writer pops the words and
//  issues PLB writes. Pixels outside the visible area are skipped.
// PARAMETERS
//  RAST_FBW_FIFO_LEN  96   FIFO word width; must be 96
//  LINE_LEN           9    row coordinate width
//  COL_LEN            10   column coordinate width
//  H_RES              640  visible columns; a pixel with x >= H_RES is not written
//  V_RES              480  visible rows; a pixel with y >= V_RES is not written
//  ERR_W              13   signed width of err and e2 (COL_LEN+3)
// PORTS
//  PLB_clk     in   1             clock
//  reset       in   1             sync, active-high
//  cmd_valid   in   1             line command valid
//  cmd_ready   out  1             high only in IDLE
//  cmd_x0      in   [0:COL_LEN-1] start column
//  cmd_y0      in   [0:LINE_LEN-1] start row
//  cmd_x1      in   [0:COL_LEN-1] end column
//  cmd_y1      in   [0:LINE_LEN-1] end row
//  cmd_color   in   [0:31]        pixel colour
//  fifo_data   out  [0:95]        pixel word to the FIFO
//  fifo_wr_en  out  1             FIFO push strobe
//  fifo_full   in   1             FIFO full; no push is allowed while high
//  busy        out  1             high when state != IDLE
//  line_done   out  1             1-cycle pulse after the last pixel is processed
// BEHAVIOUR
//  Reset is reset, synchronous, active-high; clock is PLB_clk.
//  Reset values: state=IDLE, cmd_ready=1, fifo_wr_en=0, busy=0, line_done=0, fifo_data=0.
//  Word format (bit 0 = MSB):
//   [0:15]  = zero-extended row y, row in [16-LINE_LEN:15]
//   [16:31] = zero-extended col x, col in [32-COL_LEN:31]
//   [32:63] = colour
//   [64:95] = 0 (reserved)
//  FSM IDLE -> SETUP -> DRAW -> IDLE.
//   IDLE:  on cmd_valid, latch the endpoints and colour -> SETUP.
//          The handshake is cmd_valid & cmd_ready, in the same cycle.
//   SETUP: dx=|x1-x0|, dy=-|y1-y0|, sx=(x0<x1)?+1:-1, sy=(y0<y1)?+1:-1, err=dx+dy;
//          x=x0, y=y0 -> DRAW.
//   DRAW:  one step per cycle when the FIFO can accept, otherwise hold.
//    fifo_data is combinational from x, y and colour.
//    fifo_wr_en = DRAW & ~fifo_full & (x<H_RES) & (y<V_RES), combinational.
//    Step condition: ~fifo_full. A clipped pixel also waits on ~fifo_full, which
//    keeps timing uniform.
//    On a step, if x==x1 && y==y1: -> IDLE and pulse line_done the next cycle.
//    Otherwise, with e2 = err<<1:
//     if e2 >= dy: err += dy, x += sx
//     if e2 <= dx: err += dx, y += sy
//     Both updates may apply in the same step, using the pre-step err.
//  Arithmetic: err, dx, dy and e2 are signed ERR_W. x and y never leave the endpoint
//   bounding box, so there is no wrap-around.
//  Latency: command accepted in cycle N -> first push in cycle N+2 if not full.
//   An n-pixel unclipped line with no stall pushes on cycles N+2 .. N+n+1.
//  fifo_full high: x, y and err hold; nothing is pushed. No pixel is dropped or duplicated.
//  A degenerate command (x0==x1, y0==y1) emits exactly one pixel.
//  cmd_valid in a non-IDLE state is ignored (cmd_ready=0). The source holds the command
//   until the handshake.
//  Reset mid-line: the FSM aborts to IDLE the next cycle, with no further pushes and no
//   line_done.
// TESTING
//  1. (5,7)->(5,7), colour 0xDEADBEEF -> one push; fifo_data[0:15]=7, [16:31]=5,
//     [32:63]=DEADBEEF, [64:95]=0; then line_done.
//  2. (0,0)->(3,0) -> pushes at cols 0,1,2,3, row 0, on four consecutive cycles starting
//     2 cycles after the handshake.
//  3. (3,0)->(0,0) -> cols 3,2,1,0.
//     (0,0)->(1,4) -> (0,0),(0,1),(1,2),(1,3),(1,4).
//     (0,0)->(3,3) -> (0,0),(1,1),(2,2),(3,3).
//  4. (0,0)->(7,0) with fifo_full held high for 3 cycles after the 3rd push -> exactly
//     8 pushes, cols 0..7 in order; no fifo_wr_en while full.
//  5. (638,10)->(641,10) with H_RES=640 -> pushes at cols 638 and 639 only; line_done
//     after the 4th step.
//  6. reset asserted after the 2nd push of (0,0)->(9,0) -> no further pushes, no
//     line_done, cmd_ready=1 next cycle; a new command then draws correctly.

Source files
------------

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: takes one line command and pushes one 96-bit pixel word per
// cycle into the rasterizer->framebuffer-writer FIFO, skipping off-screen pixels.
module line_rasterizer #(
  parameter int RAST_FBW_FIFO_LEN = 96,
  parameter int LINE_LEN          = 9,
  parameter int COL_LEN           = 10,
  parameter int H_RES             = 640,
  parameter int V_RES             = 480,
  parameter int ERR_W             = 13
) (
  input  logic                         PLB_clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [0:COL_LEN-1]           cmd_x0,
  input  logic [0:LINE_LEN-1]          cmd_y0,
  input  logic [0:COL_LEN-1]           cmd_x1,
  input  logic [0:LINE_LEN-1]          cmd_y1,
  input  logic [0:31]                  cmd_color,
  output logic [0:RAST_FBW_FIFO_LEN-1] fifo_data,
  output logic                         fifo_wr_en,
  input  logic                         fifo_full,
  output logic                         busy,
  output logic                         line_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, DRAW = 2'd2} state_t;

  localparam logic [COL_LEN-1:0]  H_LIM = COL_LEN'(H_RES);
  localparam logic [LINE_LEN-1:0] V_LIM = LINE_LEN'(V_RES);

  state_t state_reg, state_next;

  logic [COL_LEN-1:0]      x0_reg, x1_reg, x_reg, x_next;
  logic [LINE_LEN-1:0]     y0_reg, y1_reg, y_reg, y_next;
  logic [31:0]             color_reg;
  logic signed [ERR_W-1:0] dx_reg, dy_reg, err_reg, err_next;
  logic                    sx_neg_reg, sy_neg_reg;
  logic                    line_done_reg;

  logic signed [ERR_W-1:0] x0_ext, x1_ext, y0_ext, y1_ext;
  logic signed [ERR_W-1:0] dx_calc, dy_calc, e2;
  logic                    lt_x, lt_y, step_x, step_y, at_end, visible, step;

  assign x0_ext = $signed({{(ERR_W-COL_LEN){1'b0}}, x0_reg});
  assign x1_ext = $signed({{(ERR_W-COL_LEN){1'b0}}, x1_reg});
  assign y0_ext = $signed({{(ERR_W-LINE_LEN){1'b0}}, y0_reg});
  assign y1_ext = $signed({{(ERR_W-LINE_LEN){1'b0}}, y1_reg});

  assign lt_x    = x0_reg < x1_reg;
  assign lt_y    = y0_reg < y1_reg;
  assign dx_calc = lt_x ? (x1_ext - x0_ext) : (x0_ext - x1_ext);
  assign dy_calc = lt_y ? (y0_ext - y1_ext) : (y1_ext - y0_ext);

  assign e2      = err_reg <<< 1;
  assign step_x  = e2 >= dy_reg;
  assign step_y  = e2 <= dx_reg;
  assign at_end  = (x_reg == x1_reg) && (y_reg == y1_reg);
  assign visible = (x_reg < H_LIM) && (y_reg < V_LIM);
  assign step    = (state_reg == DRAW) && !fifo_full;

  assign fifo_data = {{(16-LINE_LEN){1'b0}}, y_reg, {(16-COL_LEN){1'b0}}, x_reg,
                      color_reg, 32'h0};
  assign line_done = line_done_reg;

  always_ff @(posedge PLB_clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    fifo_wr_en = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = SETUP;
      end
      SETUP: state_next = DRAW;
      DRAW: begin
        // A reset cycle must not leak a push of the line being aborted.
        fifo_wr_en = !fifo_full && visible && !reset;
        if (!fifo_full && at_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Both axis updates are decided from the same pre-step e2.
  always_comb begin
    err_next = err_reg;
    x_next   = x_reg;
    y_next   = y_reg;
    if (step_x) begin
      err_next = err_next + dy_reg;
      x_next   = sx_neg_reg ? (x_reg - COL_LEN'(1)) : (x_reg + COL_LEN'(1));
    end
    if (step_y) begin
      err_next = err_next + dx_reg;
      y_next   = sy_neg_reg ? (y_reg - LINE_LEN'(1)) : (y_reg + LINE_LEN'(1));
    end
  end

  always_ff @(posedge PLB_clk) begin
    if (reset) begin
      x0_reg        <= '0;
      x1_reg        <= '0;
      y0_reg        <= '0;
      y1_reg        <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      color_reg     <= '0;
      dx_reg        <= '0;
      dy_reg        <= '0;
      err_reg       <= '0;
      sx_neg_reg    <= 1'b0;
      sy_neg_reg    <= 1'b0;
      line_done_reg <= 1'b0;
    end else begin
      line_done_reg <= step && at_end;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            x0_reg    <= cmd_x0;
            y0_reg    <= cmd_y0;
            x1_reg    <= cmd_x1;
            y1_reg    <= cmd_y1;
            color_reg <= cmd_color;
          end
        end
        SETUP: begin
          dx_reg     <= dx_calc;
          dy_reg     <= dy_calc;
          err_reg    <= dx_calc + dy_calc;
          sx_neg_reg <= !lt_x;
          sy_neg_reg <= !lt_y;
          x_reg      <= x0_reg;
          y_reg      <= y0_reg;
        end
        DRAW: begin
          if (step && !at_end) begin
            err_reg <= err_next;
            x_reg   <= x_next;
            y_reg   <= y_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Bench for line_rasterizer: an integer Bresenham model predicts the pushed words; every
// cycle is checked through one sampling routine, plus hand-computed paths and timings.
module tb_line_rasterizer;

  logic        PLB_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [0:9]  cmd_x0 = '0, cmd_x1 = '0;
  logic [0:8]  cmd_y0 = '0, cmd_y1 = '0;
  logic [0:31] cmd_color = '0;
  logic [0:95] fifo_data;
  logic        fifo_wr_en;
  logic        fifo_full = 1'b0;
  logic        busy;
  logic        line_done;

  line_rasterizer dut (
    .PLB_clk(PLB_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .fifo_data(fifo_data), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .busy(busy), .line_done(line_done)
  );

  always #5 PLB_clk = ~PLB_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [0:95] exp_q[$];
  logic [0:95] cap_w[$];
  int cap_x[$], cap_y[$], push_cyc[$];
  int done_cnt = 0, done_cyc = -1;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference: the textbook integer Bresenham walk, keeping only on-screen pixels.
  function automatic int model(input int x0, y0, x1, y1, input logic [31:0] c);
    int dx, dy, sx, sy, err, e2, x, y, n;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    n = 0;
    while (n < 4096) begin
      n++;
      if (x < 640 && y < 480) exp_q.push_back({16'(y), 16'(x), c, 32'h0});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    return n;
  endfunction

  task automatic sample();
    logic [0:95] e;
    chk("ready_vs_busy", cmd_ready, !busy);
    if (fifo_wr_en) begin
      chk("no_push_while_full", fifo_full, 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_push", fifo_data, 96'h0 - 1);
      end else begin
        e = exp_q.pop_front();
        chk("push_word", fifo_data, e);
      end
      cap_w.push_back(fifo_data);
      cap_x.push_back(int'(fifo_data[16:31]));
      cap_y.push_back(int'(fifo_data[0:15]));
      push_cyc.push_back(cyc);
    end
    if (line_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge PLB_clk);
    sample();
    @(posedge PLB_clk);
    #1;
    cyc++;
  endtask

  task automatic clear_caps();
    cap_w.delete(); cap_x.delete(); cap_y.delete(); push_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic start_cmd(input int x0, y0, x1, y1, input logic [31:0] c, output int hs);
    clear_caps();
    cmd_x0 = 10'(x0); cmd_y0 = 9'(y0); cmd_x1 = 10'(x1); cmd_y1 = 9'(y1);
    cmd_color = c;
    cmd_valid = 1'b1;
    hs = cyc;
    chk("cmd_ready_at_handshake", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("busy_after_handshake", busy, 1'b1);
  endtask

  task automatic run_line(input string nm, input int x0, y0, x1, y1, input logic [31:0] c,
                          input int stall_at, stall_len, output int hs);
    int n, stall_left;
    bit stalled;
    n = model(x0, y0, x1, y1, c);
    start_cmd(x0, y0, x1, y1, c, hs);
    stalled = 0;
    stall_left = 0;
    for (int t = 0; t < 300 && done_cnt == 0; t++) begin
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) fifo_full = 1'b0;
      end else if (!stalled && stall_at > 0 && cap_x.size() == stall_at) begin
        stalled = 1;
        fifo_full = 1'b1;
        stall_left = stall_len;
      end
      tick();
    end
    fifo_full = 1'b0;
    tick();
    tick();
    chk({nm, "_line_done_once"}, 96'(done_cnt), 96'd1);
    chk({nm, "_all_pushed"}, 96'(exp_q.size()), 96'd0);
    chk({nm, "_idle_after"}, cmd_ready, 1'b1);
    exp_q.delete();
  endtask

  task automatic chk_path(input string nm, input int ex[$], input int ey[$]);
    chk({nm, "_count"}, 96'(cap_x.size()), 96'(ex.size()));
    for (int i = 0; i < ex.size() && i < cap_x.size(); i++) begin
      chk({nm, "_x"}, 96'(cap_x[i]), 96'(ex[i]));
      chk({nm, "_y"}, 96'(cap_y[i]), 96'(ey[i]));
    end
  endtask

  initial begin
    int hs;
    int ex[$], ey[$];

    // Reset state
    tick(); tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_line_done", line_done, 1'b0);
    chk("rst_fifo_data", fifo_data, 96'h0);
    reset = 1'b0;
    tick();

    // 1: degenerate command, one pixel
    run_line("t1", 5, 7, 5, 7, 32'hDEADBEEF, 0, 0, hs);
    chk("t1_pushes", 96'(cap_w.size()), 96'd1);
    if (cap_w.size() > 0) chk("t1_word", cap_w[0], 96'h0007_0005_DEADBEEF_00000000);
    if (push_cyc.size() > 0) chk("t1_push_cycle", 96'(push_cyc[0]), 96'(hs + 2));
    chk("t1_done_cycle", 96'(done_cyc), 96'(hs + 3));

    // 2: horizontal, timing
    run_line("t2", 0, 0, 3, 0, 32'h11223344, 0, 0, hs);
    ex = '{0, 1, 2, 3}; ey = '{0, 0, 0, 0};
    chk_path("t2", ex, ey);
    for (int i = 0; i < push_cyc.size(); i++) chk("t2_push_cycle", 96'(push_cyc[i]), 96'(hs + 2 + i));
    chk("t2_done_cycle", 96'(done_cyc), 96'(hs + 6));

    // 3: reversed, steep, diagonal
    run_line("t3a", 3, 0, 0, 0, 32'hA5A5A5A5, 0, 0, hs);
    ex = '{3, 2, 1, 0}; ey = '{0, 0, 0, 0};
    chk_path("t3a", ex, ey);
    run_line("t3b", 0, 0, 1, 4, 32'h00FF00FF, 0, 0, hs);
    ex = '{0, 0, 1, 1, 1}; ey = '{0, 1, 2, 3, 4};
    chk_path("t3b", ex, ey);
    run_line("t3c", 0, 0, 3, 3, 32'h12345678, 0, 0, hs);
    ex = '{0, 1, 2, 3}; ey = '{0, 1, 2, 3};
    chk_path("t3c", ex, ey);

    // 4: stall for 3 cycles after the 3rd push
    run_line("t4", 0, 0, 7, 0, 32'hCAFEF00D, 3, 3, hs);
    ex = '{0, 1, 2, 3, 4, 5, 6, 7}; ey = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_path("t4", ex, ey);
    if (push_cyc.size() == 8) chk("t4_resume_cycle", 96'(push_cyc[3]), 96'(hs + 8));
    chk("t4_done_cycle", 96'(done_cyc), 96'(hs + 13));

    // 5: right-edge clipping
    run_line("t5", 638, 10, 641, 10, 32'h0BADCAFE, 0, 0, hs);
    ex = '{638, 639}; ey = '{10, 10};
    chk_path("t5", ex, ey);
    chk("t5_done_cycle", 96'(done_cyc), 96'(hs + 6));

    // 6: reset after the 2nd push
    void'(model(0, 0, 9, 0, 32'h55AA55AA));
    start_cmd(0, 0, 9, 0, 32'h55AA55AA, hs);
    for (int t = 0; t < 50 && cap_x.size() < 2; t++) tick();
    chk("t6_two_pushes_before_reset", 96'(cap_x.size()), 96'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_cmd_ready_after_reset", cmd_ready, 1'b1);
    chk("t6_busy_after_reset", busy, 1'b0);
    exp_q.delete();
    for (int t = 0; t < 6; t++) tick();
    chk("t6_no_further_pushes", 96'(cap_x.size()), 96'd2);
    chk("t6_no_line_done", 96'(done_cnt), 96'd0);
    run_line("t6b", 0, 0, 1, 4, 32'h76543210, 0, 0, hs);
    ex = '{0, 0, 1, 1, 1}; ey = '{0, 1, 2, 3, 4};
    chk_path("t6b", ex, ey);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
